// File: rtl/ahb_rr_arbiter.sv
// ahb_rr_arbiter: AHB bus arbiter for 2..16 masters with fixed-burst
// tracking, locked transfers and SPLIT masking.
// Ports: HCLK/HRESET (sync, active-high); HBUSREQ/HLOCK per master;
//   HTRANS/HBURST/HREADY/HRESP bus status; HSPLIT split release (16 bits);
//   HGRANT one-hot grant; HMASTER address-phase owner; HMASTLOCK lock flag.
// Build option: define AHB_ARB_RR_EN for round-robin arbitration,
//   otherwise fixed priority (lowest index wins).

module ahb_rr_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    input  logic [1:0]             HRESP,
    input  logic [15:0]            HSPLIT,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [3:0]             HMASTER,
    output logic                   HMASTLOCK
);

    localparam logic [3:0] DEF_IDX    = 4'(DEFAULT_MASTER);
    localparam logic [1:0] TR_NONSEQ  = 2'b10;
    localparam logic [1:0] TR_SEQ     = 2'b11;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_SPLIT = 2'b11;

    typedef enum logic [1:0] {
        ARB,
        BURST,
        LOCKED
    } state_t;

    function automatic logic [3:0] low_idx(
        input logic [NUM_MASTERS-1:0] v
    );
        logic [3:0] r;
        r = DEF_IDX;
        for (int i = NUM_MASTERS - 1; i >= 0; i--)
            if (v[i]) r = 4'(i);
        return r;
    endfunction

    function automatic logic [NUM_MASTERS-1:0] one_hot(
        input logic [3:0] idx
    );
        logic [NUM_MASTERS-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_MASTERS; i++)
            r[i] = (4'(i) == idx);
        return r;
    endfunction

    state_t                 state, state_d;
    logic [3:0]             beat_cnt, cnt_d;
    logic [NUM_MASTERS-1:0] split_mask, split_d;
    logic [NUM_MASTERS-1:0] grant_d;
    logic [3:0]             master_d;
    logic                   mlock_d;
    logic                   load_grant;

    logic [NUM_MASTERS-1:0] eligible;
    logic [3:0]             winner;
    logic [3:0]             grant_idx;
    logic                   owner_lock;
    logic                   nonseq;
    logic                   term;
    logic [3:0]             len_m1;

    assign eligible   = HBUSREQ & ~split_mask;
    assign grant_idx  = low_idx(HGRANT);
    // HTRANS and HLOCK belong to the master currently on the address bus.
    assign owner_lock = |(HLOCK & one_hot(HMASTER));
    assign nonseq     = (HTRANS == TR_NONSEQ);
    assign term       = (HRESP != RESP_OKAY);

    always_comb begin
        unique case (HBURST[2:1])
            2'b01:   len_m1 = 4'd3;
            2'b10:   len_m1 = 4'd7;
            2'b11:   len_m1 = 4'd15;
            default: len_m1 = 4'd0;
        endcase
    end

`ifdef AHB_ARB_RR_EN
    logic [3:0]             rr_ptr;
    logic [NUM_MASTERS-1:0] above;
    logic [NUM_MASTERS-1:0] upper;

    // Requesters above the last winner go first, then wrap to the bottom.
    always_comb begin
        above = '0;
        for (int i = 0; i < NUM_MASTERS; i++)
            above[i] = (4'(i) > rr_ptr);
    end

    assign upper  = eligible & above;
    assign winner = (|upper) ? low_idx(upper) : low_idx(eligible);

    always_ff @(posedge HCLK) begin
        if (HRESET)
            rr_ptr <= DEF_IDX;
        else if (load_grant && (|eligible))
            rr_ptr <= winner;
    end
`else
    assign winner = low_idx(eligible);
`endif

    always_comb begin
        state_d    = state;
        cnt_d      = beat_cnt;
        grant_d    = HGRANT;
        master_d   = HMASTER;
        mlock_d    = HMASTLOCK;
        load_grant = 1'b0;
        if (HREADY) begin
            master_d = grant_idx;
            mlock_d  = |(HLOCK & HGRANT);
            unique case (state)
                ARB: begin
                    load_grant = 1'b1;
                    if (term) begin
                        cnt_d = '0;
                    end else if (owner_lock && nonseq) begin
                        state_d = LOCKED;
                    end else if (nonseq && (|HBURST[2:1])) begin
                        cnt_d   = len_m1;
                        state_d = BURST;
                    end
                end
                BURST: begin
                    if (term) begin
                        state_d = ARB;
                        cnt_d   = '0;
                    end else if (HTRANS == TR_SEQ) begin
                        cnt_d = beat_cnt - 4'd1;
                        // Last beat's address goes out in ARB so the
                        // next grant lands right after it.
                        if (beat_cnt == 4'd2)
                            state_d = ARB;
                    end
                end
                LOCKED: begin
                    if (term) begin
                        state_d = ARB;
                        cnt_d   = '0;
                    end else if (!owner_lock) begin
                        // Grant held one more cycle for the last
                        // locked data phase.
                        state_d = ARB;
                    end
                end
                default: begin
                    state_d = ARB;
                    cnt_d   = '0;
                end
            endcase
        end
        if (load_grant)
            grant_d = one_hot(winner);
    end

    // Set beats clear when both hit the same master in one cycle.
    always_comb begin
        split_d = split_mask & ~HSPLIT[NUM_MASTERS-1:0];
        if (HREADY && (HRESP == RESP_SPLIT))
            split_d = split_d | one_hot(HMASTER);
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state      <= ARB;
            beat_cnt   <= '0;
            split_mask <= '0;
            HGRANT     <= one_hot(DEF_IDX);
            HMASTER    <= DEF_IDX;
            HMASTLOCK  <= 1'b0;
        end else begin
            state      <= state_d;
            beat_cnt   <= cnt_d;
            split_mask <= split_d;
            HGRANT     <= grant_d;
            HMASTER    <= master_d;
            HMASTLOCK  <= mlock_d;
        end
    end

    logic unused_in;
    if (NUM_MASTERS < 16) begin : g_unused_part
        assign unused_in = ^{HBURST[0], HSPLIT[15:NUM_MASTERS]};
    end else begin : g_unused_full
        assign unused_in = HBURST[0];
    end

endmodule
